// File: rtl/sum_accum_pkg.sv
// Shared defaults and state encoding for the frame accumulator.
//
// Contents:
//   SumWDefault / CntWDefault / AccWDefault - default widths of the incoming sum,
//                                             the frame-length field and the total.
//   state_e                                  - frame FSM state (IDLE, ACCUM, DONE).
package sum_accum_pkg;

  localparam int unsigned SumWDefault = 5;
  localparam int unsigned CntWDefault = 4;
  // Wide enough for 2**CNT_W samples of the largest SUM_W value.
  localparam int unsigned AccWDefault = SumWDefault + CntWDefault;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/sum_accum.sv
// Frame accumulator placed directly after an adder's sum output.
//
// It collects frame_len samples (0 means 2**CNT_W), then presents the frame's total,
// maximum and sample count with a valid/ready handshake. While a result waits to be
// taken, no new samples are accepted.
//
// Ports:
//   clk        - clock, all logic on the rising edge
//   rst_n      - synchronous active-low reset
//   clear      - abort a partial frame (ignored while a result is pending)
//   frame_len  - samples per frame, sampled with the first sample of a frame
//   in_valid   - in_sum carries a sample
//   in_ready   - block can take a sample this cycle
//   in_sum     - unsigned sample
//   out_valid  - result available
//   out_ready  - consumer takes the result
//   out_total  - unsigned sum of the frame's samples
//   out_max    - largest sample of the frame
//   out_count  - number of samples in the frame
module sum_accum
  import sum_accum_pkg::*;
#(
  parameter int unsigned SUM_W = SumWDefault,
  parameter int unsigned CNT_W = CntWDefault,
  parameter int unsigned ACC_W = SUM_W + CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [CNT_W-1:0] frame_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [SUM_W-1:0] out_max,
  output logic [CNT_W:0]   out_count
);

  // frame_len of zero selects the full 2**CNT_W frame, hence one extra bit.
  localparam logic [CNT_W:0] FullLen = {1'b1, {CNT_W{1'b0}}};
  localparam logic [CNT_W:0] OneCnt  = {{CNT_W{1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [SUM_W-1:0] max_q, max_d;
  logic [CNT_W:0]   cnt_q, cnt_d;
  logic [CNT_W:0]   len_q, len_d;
  logic [ACC_W-1:0] out_total_q, out_total_d;
  logic [SUM_W-1:0] out_max_q, out_max_d;
  logic [CNT_W:0]   out_count_q, out_count_d;

  logic             accept;
  logic             first;
  logic             last;
  logic [CNT_W:0]   len_eff;
  logic [CNT_W:0]   cnt_new;
  logic [ACC_W-1:0] acc_new;
  logic [SUM_W-1:0] max_new;

  // Datapath for the sample being accepted this cycle. In IDLE the running values are
  // ignored so the first sample starts a fresh frame.
  always_comb begin
    in_ready = (state_q != DONE);
    // clear beats a simultaneous sample.
    accept   = in_valid && in_ready && !clear;
    first    = (state_q == IDLE);
    len_eff  = len_q;
    if (first) begin
      len_eff = (frame_len == '0) ? FullLen : {1'b0, frame_len};
    end
    cnt_new = first ? OneCnt : (cnt_q + OneCnt);
    acc_new = (first ? '0 : acc_q) + {{(ACC_W - SUM_W){1'b0}}, in_sum};
    max_new = (first || (in_sum > max_q)) ? in_sum : max_q;
    last    = (cnt_new == len_eff);
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    max_d       = max_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    out_total_d = out_total_q;
    out_max_d   = out_max_q;
    out_count_d = out_count_q;

    unique case (state_q)
      IDLE, ACCUM: begin
        if (clear) begin
          state_d = IDLE;
          acc_d   = '0;
          max_d   = '0;
          cnt_d   = '0;
        end else if (accept) begin
          acc_d = acc_new;
          max_d = max_new;
          cnt_d = cnt_new;
          len_d = len_eff;
          if (last) begin
            state_d     = DONE;
            out_total_d = acc_new;
            out_max_d   = max_new;
            out_count_d = cnt_new;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      DONE: begin
        // Result registers keep their value after the handoff until the next frame ends.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      max_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      out_total_q <= '0;
      out_max_q   <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      max_q       <= max_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      out_total_q <= out_total_d;
      out_max_q   <= out_max_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign out_total = out_total_q;
  assign out_max   = out_max_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_sum_accum.sv
// Self-checking bench for sum_accum: a frame-level model (list of samples, target length)
// predicts handshake and result outputs every cycle; directed scenarios add literal checks.
module tb_sum_accum;

  localparam int unsigned SUM_W = 5;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned ACC_W = 9;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear;
  logic [CNT_W-1:0] frame_len;
  logic             in_valid;
  logic             in_ready;
  logic [SUM_W-1:0] in_sum;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_total;
  logic [SUM_W-1:0] out_max;
  logic [CNT_W:0]   out_count;

  always #5 clk = ~clk;

  sum_accum #(
    .SUM_W(SUM_W),
    .CNT_W(CNT_W),
    .ACC_W(ACC_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .frame_len(frame_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sum   (in_sum),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_total(out_total),
    .out_max  (out_max),
    .out_count(out_count)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Frame-level model: a result is pending (m_done) or samples are being collected.
  bit m_done = 1'b0;
  int m_len  = 0;
  int samples[$];
  int exp_total = 0;
  int exp_max   = 0;
  int exp_count = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_done    = 1'b0;
      m_len     = 0;
      samples.delete();
      exp_total = 0;
      exp_max   = 0;
      exp_count = 0;
    end else if (m_done) begin
      if (out_ready) m_done = 1'b0;
    end else if (clear) begin
      samples.delete();
    end else if (in_valid) begin
      if (samples.size() == 0) m_len = (frame_len == 0) ? 16 : int'(frame_len);
      samples.push_back(int'(in_sum));
      if (samples.size() == m_len) begin
        exp_total = 0;
        exp_max   = 0;
        foreach (samples[i]) begin
          exp_total += samples[i];
          if (samples[i] > exp_max) exp_max = samples[i];
        end
        exp_count = samples.size();
        samples.delete();
        m_done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc.in_ready", in_ready, !m_done);
      check("cyc.out_valid", out_valid, m_done);
      check("cyc.out_total", out_total, exp_total);
      check("cyc.out_max", out_max, exp_max);
      check("cyc.out_count", out_count, exp_count);
    end
  end

  // One cycle of stimulus, applied on the falling edge.
  task automatic cyc(input bit r, input bit v, input int fl, input int s, input bit clr,
                     input bit ordy);
    logic [31:0] flv, sv;
    @(negedge clk);
    flv       = fl;
    sv        = s;
    rst_n     = r;
    in_valid  = v;
    frame_len = flv[CNT_W-1:0];
    in_sum    = sv[SUM_W-1:0];
    clear     = clr;
    out_ready = ordy;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic lit(input string name, input int tot, input int mx, input int cnt);
    check({name, ".total"}, out_total, tot);
    check({name, ".max"}, out_max, mx);
    check({name, ".count"}, out_count, cnt);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    frame_len = '0;
    in_sum    = '0;
    clear     = 1'b0;
    out_ready = 1'b1;
    cyc(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    chk_en = 1'b1;
    idle(1);
    lit("reset", 0, 0, 0);
    check("reset.in_ready", in_ready, 1);
    check("reset.out_valid", out_valid, 0);

    // 3-sample frame back to back, result one cycle after the last accept.
    cyc(1'b1, 1'b1, 3, 8, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 3, 7, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 3, 10, 1'b0, 1'b1);
    @(posedge clk);
    #1 check("f3.latency", out_valid, 1);
    idle(3);
    lit("f3", 25, 10, 3);

    // Full 16-sample frame of the largest value.
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 0, 31, 1'b0, 1'b1);
    idle(2);
    lit("f16", 496, 31, 16);

    // Back-pressure: result held, samples and clear ignored while pending.
    cyc(1'b1, 1'b1, 2, 4, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 2, 9, 1'b0, 1'b0);
    repeat (5) cyc(1'b1, 1'b1, 2, 31, 1'b1, 1'b0);
    @(posedge clk);
    #1 check("hold.out_valid", out_valid, 1);
    check("hold.in_ready", in_ready, 0);
    lit("hold", 13, 9, 2);
    cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
    @(posedge clk);
    #1 check("hold.release", out_valid, 0);
    idle(2);
    lit("hold.after", 13, 9, 2);

    // clear with a simultaneous sample drops both the frame and the sample.
    cyc(1'b1, 1'b1, 4, 3, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 4, 6, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 4, 15, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1, 5, 1'b0, 1'b1);
    idle(2);
    lit("clear", 5, 5, 1);

    // frame_len change mid-frame is ignored.
    cyc(1'b1, 1'b1, 2, 2, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1, 6, 1'b0, 1'b1);
    idle(2);
    lit("lenchg", 8, 6, 2);

    // Gaps between samples; max is not the last sample.
    cyc(1'b1, 1'b1, 3, 1, 1'b0, 1'b1);
    idle(2);
    cyc(1'b1, 1'b1, 0, 30, 1'b0, 1'b1);
    idle(1);
    cyc(1'b1, 1'b1, 0, 2, 1'b0, 1'b1);
    idle(2);
    lit("gaps", 33, 30, 3);

    // Reset mid-frame.
    cyc(1'b1, 1'b1, 4, 7, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 4, 7, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 4, 7, 1'b1, 1'b1);
    @(posedge clk);
    #1 lit("rst.mid", 0, 0, 0);
    check("rst.mid.in_ready", in_ready, 1);
    cyc(1'b1, 1'b1, 1, 1, 1'b0, 1'b1);
    idle(2);
    lit("rst.next", 1, 1, 1);

    // Reset while a result is pending.
    cyc(1'b1, 1'b1, 1, 20, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    @(posedge clk);
    #1 check("rst.done.out_valid", out_valid, 0);
    lit("rst.done", 0, 0, 0);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sum_accum.md
SUM_ACCUM -- requirements
Module: sum_accum

Interface
REQ-001 Parameter SUM_W, default 5, width of each incoming adder sum.
REQ-002 Parameter CNT_W, default 4, width of frame_len; maximum frame is 2**CNT_W samples.
REQ-003 Parameter ACC_W, default SUM_W+CNT_W (9), width of out_total.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 clear  input  1  synchronous abort of a partial frame.
REQ-007 frame_len  input  CNT_W  samples per frame; 0 means 2**CNT_W (16).
REQ-008 in_valid  input  1  in_sum is valid.
REQ-009 in_ready  output  1  block can accept a sample.
REQ-010 in_sum  input  SUM_W  adder result, unsigned.
REQ-011 out_valid  output  1  frame result available.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 out_total  output  ACC_W  unsigned sum of all samples in the frame.
REQ-014 out_max  output  SUM_W  largest sample in the frame.
REQ-015 out_count  output  CNT_W+1  number of samples in the frame.

Function
REQ-016 The block SHALL use a three-state FSM: IDLE, ACCUM, DONE.
REQ-017 A sample SHALL be accepted only in a cycle where in_valid && in_ready.
REQ-018 in_ready SHALL be 1 in IDLE and ACCUM and 0 in DONE.
REQ-019 On acceptance in IDLE, the block SHALL latch len = frame_len (0 maps to 16), load acc=in_sum, max=in_sum, cnt=1; go to DONE if len==1, else to ACCUM.
REQ-020 On acceptance in ACCUM, the block SHALL set acc+=in_sum, cnt+=1, max=max(max,in_sum); go to DONE when the new cnt equals len.
REQ-021 frame_len SHALL be sampled only at the first accepted sample; changes mid-frame SHALL be ignored.
REQ-022 Cycles without acceptance in IDLE/ACCUM SHALL leave all state unchanged (gaps allowed).
REQ-023 out_valid SHALL be 1 exactly while in DONE, starting the cycle after the final sample is accepted (latency 1).
REQ-024 out_total, out_max and out_count SHALL be registered and stable while out_valid is 1.
REQ-025 In DONE with out_ready=1, the block SHALL return to IDLE on the next edge; with out_ready=0 it SHALL hold indefinitely.
REQ-026 Accumulation SHALL be zero-extended to ACC_W; worst case 16*31=496 fits in 9 bits, so no overflow handling is required.
REQ-027 clear=1 in IDLE or ACCUM SHALL discard the partial frame and go to IDLE; if a sample is offered in the same cycle, clear SHALL win and the sample SHALL be dropped.
REQ-028 clear SHALL be ignored in DONE; a completed result is always delivered.
REQ-029 Outputs SHALL retain the last delivered result after return to IDLE until the next frame completes.

Reset
REQ-030 While rst_n=0 at a clock edge: state=IDLE, acc=0, max=0, cnt=0, len=0, out_total=0, out_max=0, out_count=0, out_valid=0.
REQ-031 Reset SHALL take priority over clear and over any handshake, including mid-frame and in DONE.
REQ-032 in_ready SHALL be 1 in the first cycle after reset is released.

Structure
REQ-033 Package sum_accum_pkg SHALL hold SUM_W, CNT_W and ACC_W defaults and the state enum typedef (IDLE, ACCUM, DONE).
REQ-034 The block SHALL be a single module with no sub-module; it connects directly downstream of the adder's sum output.

Verification
REQ-035 frame_len=3, sums 8,7,10 back-to-back, out_ready=1 -> out_valid one cycle after the third accept; total=25, max=10, count=3.
REQ-036 frame_len=0, sixteen samples of 31 -> total=496, max=31, count=16.
REQ-037 frame_len=2, sums 4,9, out_ready=0 for 5 cycles -> out_valid and outputs held, in_ready=0; released 1 cycle after out_ready=1.
REQ-038 frame_len=4, sums 3,6, then clear together with in_valid carrying 15; then frame_len=1, sum 5 -> total=5, max=5, count=1.
REQ-039 frame_len=2 latched, changed to 1 after the first sample (2) -> frame still closes after second sample (6); total=8, count=2.
REQ-040 rst_n=0 mid-frame after samples 7,7 -> all outputs 0, next frame frame_len=1, sum 1 -> total=1.
